i2c_target_regfile: RTL
=======================

// Module: i2c_target_regfile
// PURPOSE
//  Synthesizable I2C target (slave) with a byte-wide register file. It is the responder
//  for the si570_if I2C master, and it emulates a Si570-style device in system benches.
//  Open-drain style: sda_oen_o=0 pulls SDA low, 1 releases it.
//  Written bytes are exported as write strobes. The register file is readable from the host side.
// PARAMETERS
//  g_address    7'h55  7-bit target address.
//  g_num_regs   16     register count, power of 2, range 2..256.
//  g_filter_len 3      consecutive equal samples needed to accept a level (glitch filter only).
// PORTS
//  clk_sys       in   1               system clock
//  rst_n         in   1               reset, asynchronous, active-high
//  scl_i         in   1               SCL pad input
//  sda_i         in   1               SDA pad input
//  sda_oen_o     out  1               SDA output enable, active-low (0 = drive low)
//  wr_stb_o      out  1               1-cycle pulse per accepted data byte
//  wr_addr_o     out  log2(g_num_regs) register index of the write
//  wr_data_o     out  8               data byte of the write
//  host_addr_i   in   log2(g_num_regs) host read index
//  host_data_o   out  8               regs[host_addr_i], registered, latency 1
//  busy_o        out  1               high from START to STOP
// BEHAVIOUR
//  - Reset values: sda_oen_o=1, wr_stb_o=0, wr_addr_o=0, wr_data_o=0, host_data_o=0,
//    busy_o=0, all regs=0, ptr=0, state=IDLE.
//  - Input path: 2-FF synchronizer on scl_i/sda_i, then optional filter (see CONFIGURATION).
//  - Events are decoded from filtered levels:
//    - START/Sr: SDA falls while SCL=1.
//    - STOP: SDA rises while SCL=1.
//    - Bits are sampled on SCL rise. The target changes sda_oen_o only on detected SCL fall.
//  - FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
//    - START in any state -> ADDR, bit counter cleared, busy_o=1.
//    - ADDR: shift 8 bits, MSB first.
//      - Address match -> ADDR_ACK; sda_oen_o=0 for the ninth SCL period.
//      - Mismatch -> IGNORE; SDA released until the next START/STOP.
//    - ADDR_ACK:
//      - R/W=0 -> PTR.
//      - R/W=1 -> RDATA; load regs[ptr] and drive its MSB on the ACK SCL fall.
//    - PTR: byte -> ptr = byte mod g_num_regs; ACK; -> WDATA.
//    - WDATA: byte -> regs[ptr] <= byte; wr_stb_o pulses 1 cycle with the old ptr; ACK;
//      ptr++ (wraps at g_num_regs); -> WDATA.
//    - RDATA: drive 8 bits, then release SDA for the master ACK bit.
//      - Master ACK (SDA=0 at SCL rise) -> ptr++, reload, continue.
//      - NACK -> ptr++, IGNORE.
//    - STOP in any state -> IDLE; SDA released on the same cycle; busy_o=0.
//  - Boundaries:
//    - STOP or Sr mid-byte: partial byte discarded, no strobe, ptr unchanged.
//    - Sr keeps ptr, so a pointer write followed by Sr+read reads from that pointer.
//    - ptr wrap: g_num_regs-1 -> 0 for both reads and writes.
//    - Host read and I2C write to the same index in the same cycle: host_data_o returns the old value.
//    - Reset asserted mid-transfer: SDA released immediately, FSM -> IDLE.
//  - SCL is never driven; there is no clock stretching.
// CONFIGURATION
//  - I2C_TGT_GLITCH_FILTER_EN defined:
//    - Each synced line updates only after g_filter_len identical consecutive samples.
//    - Pulses shorter than g_filter_len cycles are ignored.
//    - Adds g_filter_len cycles of latency.
//  - Undefined: the synchronizer output is used directly; 1-cycle glitches are seen as edges.
// TESTING
//  - Write 0xAA(addr 0x55,W), 0x07, 0xCA, 0xFE, STOP -> ACK on all 4 bytes;
//    wr_stb_o x2 (7,CA),(8,FE); regs[7]=CA, regs[8]=FE.
//  - Continue: START 0xAA,0x07, Sr 0xAB, read 2 bytes ACK/NACK, STOP -> SDA carries CA then FE;
//    host_addr_i=8 gives host_data_o=FE one cycle later.
//  - START 0xA8 (addr 0x54) -> ninth bit NACK (SDA=1); sda_oen_o stays 1 until STOP;
//    no wr_stb_o.
//  - g_num_regs=16: ptr 0x0F, data 0x11, 0x22 -> regs[15]=11, regs[0]=22; 0x1F as pointer -> ptr=15.
//  - STOP after 5 data bits; rst_n pulse during RDATA with SDA driven low ->
//    no strobe, regs unchanged; sda_oen_o=1 within 1 cycle; busy_o=0.
//  - With I2C_TGT_GLITCH_FILTER_EN and g_filter_len=3:
//    - 2-cycle SDA low pulse while SCL=1 -> no START, busy_o stays 0.
//    - Without the macro -> busy_o=1.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target (slave) with a byte-wide register file.
// The first written byte after the address sets the register pointer; later written
// bytes go to regs[ptr] and bump the pointer. Reads return regs[ptr], auto-incrementing.
// SDA is open-drain: sda_oen_o=0 pulls the line low. SCL is never driven.
// Optional macro I2C_TGT_GLITCH_FILTER_EN adds a g_filter_len-sample filter on SCL/SDA.
// Ports:
//   clk_sys, rst_n       clock; reset is asynchronous and active-high (rst_n=1 resets)
//   scl_i, sda_i         bus pad inputs
//   sda_oen_o            SDA output enable, active-low
//   wr_stb_o/addr/data   one-cycle strobe per accepted data byte, with index and data
//   host_addr_i          host read index
//   host_data_o          regs[host_addr_i], one cycle latency
//   busy_o               high between START and STOP
module i2c_target_regfile #(
    parameter logic [6:0]  g_address    = 7'h55,
    parameter int unsigned g_num_regs   = 16,
    parameter int unsigned g_filter_len = 3
) (
    input  logic                          clk_sys,
    input  logic                          rst_n,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          sda_oen_o,
    output logic                          wr_stb_o,
    output logic [$clog2(g_num_regs)-1:0] wr_addr_o,
    output logic [7:0]                    wr_data_o,
    input  logic [$clog2(g_num_regs)-1:0] host_addr_i,
    output logic [7:0]                    host_data_o,
    output logic                          busy_o
);
    localparam int unsigned AW = $clog2(g_num_regs);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_e;

    // Two-flop synchronizers, reset to the idle bus level
    logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_f, sda_f;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(g_filter_len + 1);
    logic           scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;
    logic [FCW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

    // A new level is accepted only after g_filter_len consecutive equal samples
    always_comb begin
        scl_flt_d = scl_flt_q;
        scl_cnt_d = '0;
        sda_flt_d = sda_flt_q;
        sda_cnt_d = '0;
        if (scl_sync_q[1] != scl_flt_q) begin
            if (scl_cnt_q == FCW'(g_filter_len - 1)) scl_flt_d = scl_sync_q[1];
            else                                     scl_cnt_d = scl_cnt_q + FCW'(1);
        end
        if (sda_sync_q[1] != sda_flt_q) begin
            if (sda_cnt_q == FCW'(g_filter_len - 1)) sda_flt_d = sda_sync_q[1];
            else                                     sda_cnt_d = sda_cnt_q + FCW'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
        end else begin
            scl_flt_q <= scl_flt_d;
            sda_flt_q <= sda_flt_d;
            scl_cnt_q <= scl_cnt_d;
            sda_cnt_q <= sda_cnt_d;
        end
    end

    assign scl_f = scl_flt_q;
    assign sda_f = sda_flt_q;
`else
    logic unused_filter_len_c;
    assign unused_filter_len_c = ^32'(g_filter_len);
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    // Bus event decode from previous and current filtered levels
    logic scl_p_q, sda_p_q;
    logic start_c, stop_c, scl_rise_c, scl_fall_c;

    assign start_c    = scl_p_q & scl_f & sda_p_q & ~sda_f;
    assign stop_c     = scl_p_q & scl_f & ~sda_p_q & sda_f;
    assign scl_rise_c = ~scl_p_q & scl_f;
    assign scl_fall_c = scl_p_q & ~scl_f;

    state_e          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            rw_q, rw_d;
    logic            sda_oen_q, sda_oen_d;
    logic            busy_q, busy_d;
    logic            wr_stb_q, wr_stb_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [7:0]      host_data_q, host_data_d;
    logic            reg_we_c;
    logic [7:0]      regs_q [g_num_regs];

    // Protocol FSM: receive bits on SCL rise, change SDA only on SCL fall
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oen_d   = sda_oen_q;
        busy_d      = busy_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we_c    = 1'b0;
        host_data_d = regs_q[host_addr_i];

        if (stop_c) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oen_d = 1'b1;
            busy_d    = 1'b0;
        end else if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oen_d = 1'b1;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise_c && bit_cnt_q < 4'd8) begin
                        shreg_d   = {shreg_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_c && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            if (shreg_q[7:1] == g_address) begin
                                rw_d      = shreg_q[0];
                                sda_oen_d = 1'b0;
                                state_d   = ADDR_ACK;
                            end else begin
                                state_d   = IGNORE;
                            end
                        end else if (state_q == PTR) begin
                            ptr_d     = shreg_q[AW-1:0];
                            sda_oen_d = 1'b0;
                            state_d   = PTR_ACK;
                        end else begin
                            reg_we_c  = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = shreg_q;
                            ptr_d     = ptr_q + AW'(1);
                            sda_oen_d = 1'b0;
                            state_d   = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_c) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            shreg_d   = regs_q[ptr_q];
                            sda_oen_d = regs_q[ptr_q][7];
                            state_d   = RDATA;
                        end else begin
                            sda_oen_d = 1'b1;
                            state_d   = PTR;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall_c) begin
                        bit_cnt_d = 4'd0;
                        sda_oen_d = 1'b1;
                        state_d   = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise_c) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_c) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = 4'd0;
                            sda_oen_d = 1'b1;
                            state_d   = RACK;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_oen_d = shreg_q[6];
                        end
                    end
                end
                RACK: begin
                    // bit_cnt marks that the master ACK was seen and the next byte is due
                    if (scl_rise_c) begin
                        ptr_d = ptr_q + AW'(1);
                        if (sda_f) state_d   = IGNORE;
                        else       bit_cnt_d = 4'd1;
                    end else if (scl_fall_c && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd0;
                        shreg_d   = regs_q[ptr_q];
                        sda_oen_d = regs_q[ptr_q][7];
                        state_d   = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_p_q     <= 1'b1;
            sda_p_q     <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= 8'h00;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oen_q   <= 1'b1;
            busy_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            host_data_q <= 8'h00;
            for (int i = 0; i < int'(g_num_regs); i++) regs_q[i] <= 8'h00;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_p_q     <= scl_f;
            sda_p_q     <= sda_f;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oen_q   <= sda_oen_d;
            busy_q      <= busy_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            host_data_q <= host_data_d;
            if (reg_we_c) regs_q[ptr_q] <= shreg_q;
        end
    end

    assign sda_oen_o   = sda_oen_q;
    assign busy_o      = busy_q;
    assign wr_stb_o    = wr_stb_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign host_data_o = host_data_q;

endmodule
